dist_sequencer: RTL and testbench

DIST_SEQUENCER -- requirements
Module: dist_sequencer

---
 rtl/dist_sequencer.sv | 170 +++++++++++++++++
 tb/tb_dist_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dist_sequencer.sv
// Control sequencer for a register-file/ALU distance datapath: loads two vectors, clears the accumulator, runs SUB/ACC per element, then reads out.
// Optional Abort input is compiled in with the DIST_SEQ_ABORT_EN macro.
module dist_sequencer #(
    parameter int num_bit_of_data   = 8,
    parameter int num_bit_of_column = 4
) (
    input  logic                         CLK,
    input  logic                         RST_n,
    input  logic                         Start,
    input  logic                         Mode,
    input  logic [num_bit_of_column-1:0] Length,
    input  logic                         In_valid,
`ifdef DIST_SEQ_ABORT_EN
    input  logic                         Abort,
`endif
    output logic                         In_ready,
    output logic                         Write_en,
    output logic                         Mux_in,
    output logic [num_bit_of_column-1:0] Addr_in,
    output logic [num_bit_of_column-1:0] Addr_out1,
    output logic [num_bit_of_column-1:0] Addr_out2,
    output logic [1:0]                   Opcode,
    output logic                         Out_enable,
    output logic                         Busy,
    output logic                         Done,
    output logic [num_bit_of_data-1:0]   Distance
);

    localparam int CW = num_bit_of_column;
    localparam int DW = num_bit_of_data;

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] ADDR_ACC = '1;
    localparam logic [CW-1:0] ADDR_TMP = ADDR_ACC - ONE;
    localparam logic [CW-1:0] HALF     = CW'(1) << (CW - 1);
    localparam logic [CW-1:0] LEN_MAX  = HALF - CW'(2);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ABS  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CLR  = 3'd2,
        S_SUB  = 3'd3,
        S_ACC  = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    state_t        state, next_state;
    logic          mode_q;
    logic [CW-1:0] len_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] idx;
    logic [CW-1:0] len_clamped;
    logic [CW-1:0] last_load;
    logic          abort_hit;

`ifdef DIST_SEQ_ABORT_EN
    assign abort_hit = Abort && (state != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // The top two register-file rows hold the accumulator and the per-element difference.
    assign len_clamped = (Length > LEN_MAX) ? LEN_MAX : Length;
    assign last_load   = (len_q << 1) - ONE;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (Start) next_state = (len_clamped == '0) ? S_CLR : S_LOAD;
            S_LOAD: if (In_valid && (cnt == last_load)) next_state = S_CLR;
            S_CLR:  next_state = (len_q == '0) ? S_OUT : S_SUB;
            S_SUB:  next_state = S_ACC;
            S_ACC:  next_state = (idx == len_q - ONE) ? S_OUT : S_SUB;
            S_OUT:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (abort_hit) next_state = S_IDLE;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            mode_q   <= 1'b0;
            len_q    <= '0;
            cnt      <= '0;
            idx      <= '0;
            Distance <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        mode_q <= Mode;
                        len_q  <= len_clamped;
                        cnt    <= '0;
                        idx    <= '0;
                    end
                end
                S_LOAD: if (In_valid) cnt <= cnt + ONE;
                S_ACC:  idx <= idx + ONE;
                default: ;
            endcase
            // Loaded on entry to OUT so the count is valid in the same cycle as Done.
            if (next_state == S_OUT) Distance <= DW'(len_q);
        end
    end

    always_comb begin
        In_ready   = 1'b0;
        Write_en   = 1'b0;
        Mux_in     = 1'b0;
        Addr_in    = '0;
        Addr_out1  = '0;
        Addr_out2  = '0;
        Opcode     = OP_PASS;
        Out_enable = 1'b0;
        Done       = 1'b0;
        Busy       = (state != S_IDLE);
        case (state)
            S_LOAD: begin
                In_ready = 1'b1;
                Write_en = In_valid;
                Addr_in  = (cnt < len_q) ? cnt : HALF + (cnt - len_q);
            end
            S_CLR: begin
                Opcode    = OP_SUB;
                Addr_out1 = ADDR_ACC;
                Addr_out2 = ADDR_ACC;
                Write_en  = 1'b1;
                Mux_in    = 1'b1;
                Addr_in   = ADDR_ACC;
            end
            S_SUB: begin
                Opcode    = mode_q ? OP_SUB : OP_ABS;
                Addr_out1 = idx;
                Addr_out2 = HALF + idx;
                Write_en  = 1'b1;
                Mux_in    = 1'b1;
                Addr_in   = ADDR_TMP;
            end
            S_ACC: begin
                Opcode    = OP_ADD;
                Addr_out1 = ADDR_ACC;
                Addr_out2 = ADDR_TMP;
                Write_en  = 1'b1;
                Mux_in    = 1'b1;
                Addr_in   = ADDR_ACC;
            end
            S_OUT: begin
                Opcode     = OP_PASS;
                Addr_out1  = ADDR_ACC;
                Out_enable = 1'b1;
                Done       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dist_sequencer.sv
// Randomized self-checking bench for dist_sequencer against an expected-write-list model.
module tb_dist_sequencer;

    localparam int DW   = 8;
    localparam int CW   = 4;
    localparam int HALF = 8;

    localparam logic [CW-1:0] AMAX = '1;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ABS  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          in_valid = 1'b0;
    logic [CW-1:0] length = '0;
`ifdef DIST_SEQ_ABORT_EN
    logic          abort = 1'b0;
`endif

    logic          in_ready, write_en, mux_in, out_enable, busy, done;
    logic [CW-1:0] addr_in, addr_out1, addr_out2;
    logic [1:0]    opcode;
    logic [DW-1:0] distance;

    dist_sequencer #(.num_bit_of_data(DW), .num_bit_of_column(CW)) dut (
        .CLK(clk), .RST_n(rst_n), .Start(start), .Mode(mode), .Length(length),
        .In_valid(in_valid),
`ifdef DIST_SEQ_ABORT_EN
        .Abort(abort),
`endif
        .In_ready(in_ready), .Write_en(write_en), .Mux_in(mux_in),
        .Addr_in(addr_in), .Addr_out1(addr_out1), .Addr_out2(addr_out2),
        .Opcode(opcode), .Out_enable(out_enable), .Busy(busy), .Done(done),
        .Distance(distance)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          alu;
        logic          mux;
        logic [CW-1:0] ain;
        logic [CW-1:0] a1;
        logic [CW-1:0] a2;
        logic [1:0]    op;
    } wr_t;

    wr_t           exp_q[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] last_dist = '0;

    // Expected register-file writes for one run, in order, from the sequencing rules.
    task automatic build_expect(input logic m, input int L);
        wr_t w;
        exp_q.delete();
        for (int k = 0; k < 2 * L; k++) begin
            w.alu = 1'b0; w.mux = 1'b0; w.a1 = '0; w.a2 = '0; w.op = OP_PASS;
            w.ain = CW'((k < L) ? k : HALF + k - L);
            exp_q.push_back(w);
        end
        w.alu = 1'b1; w.mux = 1'b1; w.ain = AMAX; w.a1 = AMAX; w.a2 = AMAX; w.op = OP_SUB;
        exp_q.push_back(w);
        for (int i = 0; i < L; i++) begin
            w.ain = AMAX - 4'd1; w.a1 = CW'(i); w.a2 = CW'(HALF + i);
            w.op = m ? OP_SUB : OP_ABS;
            exp_q.push_back(w);
            w.ain = AMAX; w.a1 = AMAX; w.a2 = AMAX - 4'd1; w.op = OP_ADD;
            exp_q.push_back(w);
        end
    endtask

    task automatic run_seq(input logic m, input logic [CW-1:0] len, input int vpct, input bit pulse_start);
        int  L, nload, last_load, nwr;
        bit  finished, pulsed;
        wr_t w;
        L = (int'(len) > HALF - 2) ? HALF - 2 : int'(len);
        build_expect(m, L);
        nload = 0; last_load = 0; nwr = 0; finished = 1'b0; pulsed = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; mode = m; length = len;
        @(posedge clk); #1;
        start = 1'b0; mode = 1'($urandom); length = CW'($urandom);
        for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            in_valid = ($urandom_range(99) < vpct);
            if (pulse_start && !pulsed && L > 0 && nwr >= 2 * L + 2 && ((nwr - 2 * L) % 2 == 0)) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            @(negedge clk);
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL busy cyc=%0d got=%b want=1", cyc, busy);
            end
            if (nload < 2 * L) begin
                vectors++;
                if (in_ready !== 1'b1 || write_en !== in_valid) begin
                    miscompares++;
                    $display("FAIL load_handshake cyc=%0d in_ready=%b write_en=%b want 1/%b", cyc, in_ready, write_en, in_valid);
                end
                if (in_valid) begin
                    nload++;
                    last_load = cyc;
                end
            end else begin
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL in_ready_low cyc=%0d got=%b want=0", cyc, in_ready);
                end
            end
            if (write_en === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_write cyc=%0d addr_in=%0d want no write", cyc, addr_in);
                end else begin
                    w = exp_q.pop_front();
                    nwr++;
                    if (mux_in !== w.mux || addr_in !== w.ain) begin
                        miscompares++;
                        $display("FAIL write_dest cyc=%0d mux=%b addr_in=%0d want %b/%0d", cyc, mux_in, addr_in, w.mux, w.ain);
                    end
                    if (w.alu) begin
                        vectors++;
                        if (addr_out1 !== w.a1 || addr_out2 !== w.a2 || opcode !== w.op) begin
                            miscompares++;
                            $display("FAIL alu_op cyc=%0d a1=%0d a2=%0d op=%b want %0d/%0d/%b",
                                     cyc, addr_out1, addr_out2, opcode, w.a1, w.a2, w.op);
                        end
                    end
                end
            end
            if (done === 1'b1) begin
                finished = 1'b1;
                vectors++;
                if (out_enable !== 1'b1 || distance !== DW'(L) || exp_q.size() != 0) begin
                    miscompares++;
                    $display("FAIL done_state out_en=%b dist=%0d pending=%0d want 1/%0d/0", out_enable, distance, exp_q.size(), L);
                end
                vectors++;
                if ((L > 0) ? (cyc - last_load != 2 * L + 2) : (cyc != 2)) begin
                    miscompares++;
                    $display("FAIL done_timing cyc=%0d last_load=%0d L=%0d", cyc, last_load, L);
                end
                vectors++;
                if (addr_out1 !== AMAX || opcode !== OP_PASS) begin
                    miscompares++;
                    $display("FAIL out_read a1=%0d op=%b want %0d/%b", addr_out1, opcode, AMAX, OP_PASS);
                end
            end else begin
                vectors++;
                if (out_enable !== 1'b0) begin
                    miscompares++;
                    $display("FAIL out_enable_early cyc=%0d got=%b want=0", cyc, out_enable);
                end
            end
        end
        if (!finished) begin
            miscompares++;
            $display("FAIL timeout no Done for mode=%b len=%0d", m, len);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || write_en !== 1'b0 || distance !== DW'(L) || opcode !== OP_PASS) begin
            miscompares++;
            $display("FAIL idle_after busy=%b done=%b we=%b dist=%0d op=%b want 0/0/0/%0d/11", busy, done, write_en, distance, opcode, L);
        end
        last_dist = DW'(L);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || write_en !== 1'b0 || in_ready !== 1'b0 || out_enable !== 1'b0 ||
            addr_in !== '0 || addr_out1 !== '0 || addr_out2 !== '0 || distance !== '0 || opcode !== OP_PASS) begin
            miscompares++;
            $display("FAIL reset_state busy=%b done=%b we=%b rdy=%b ai=%0d a1=%0d a2=%0d dist=%0d op=%b",
                     busy, done, write_en, in_ready, addr_in, addr_out1, addr_out2, distance, opcode);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if (write_en !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ignores_valid we=%b busy=%b want 0/0", write_en, busy);
        end
        in_valid = 1'b0;
        last_dist = '0;
    endtask

    task automatic test_reset_mid_sub;
        bit in_sub;
        in_sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; length = 4'd3;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 40 && !in_sub; c++) begin
            @(negedge clk);
            if (write_en === 1'b1 && opcode === OP_ABS) in_sub = 1'b1;
        end
        vectors++;
        if (!in_sub) begin
            miscompares++;
            $display("FAIL reach_sub got no SUB step within 40 cycles");
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || write_en !== 1'b0 || done !== 1'b0 || addr_out1 !== '0 || addr_out2 !== '0 ||
            addr_in !== '0 || distance !== '0) begin
            miscompares++;
            $display("FAIL async_reset busy=%b we=%b done=%b a1=%0d a2=%0d ai=%0d dist=%0d want all 0",
                     busy, write_en, done, addr_out1, addr_out2, addr_in, distance);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (write_en !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold we=%b busy=%b want 0/0", write_en, busy);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        last_dist = '0;
    endtask

`ifdef DIST_SEQ_ABORT_EN
    task automatic test_abort;
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; length = 4'd4;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || write_en !== 1'b0 || distance !== last_dist) begin
            miscompares++;
            $display("FAIL abort busy=%b done=%b we=%b dist=%0d want 0/0/0/%0d", busy, done, write_en, distance, last_dist);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom);
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || write_en !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_quiet done=%b we=%b want 0/0", done, write_en);
            end
        end
        in_valid = 1'b0;
    endtask
`endif

    task automatic test_random;
        for (int n = 0; n < 12; n++) begin
            run_seq(1'($urandom), CW'($urandom), $urandom_range(100, 30), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        run_seq(1'b0, 4'd3, 100, 1'b0);   // basic Manhattan run, contiguous load
        run_seq(1'b1, 4'd2, 100, 1'b0);   // signed-sum opcode
        run_seq(1'b0, 4'd15, 100, 1'b0);  // clamp to HALF-2, extra valid refused
        run_seq(1'b1, 4'd0, 100, 1'b0);   // empty vector
        run_seq(1'b0, 4'd4, 100, 1'b1);   // Start during ACC ignored
        run_seq(1'b1, 4'd5, 40, 1'b0);    // gappy load
        test_reset_mid_sub();
        run_seq(1'b0, 4'd1, 100, 1'b0);   // recovers after reset
`ifdef DIST_SEQ_ABORT_EN
        test_abort();
        run_seq(1'b0, 4'd2, 100, 1'b0);
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
